learn_mode_grader: RTL and testbench

- Parameterised note-following trainer for the piano learning mode.
- Fetches song notes from an external song ROM and drives the expected note to the LED/tone path.
- Waits for the player to press the matching key, measures how long it is held, and grades timing against the note's duration. Accumulates a saturating score.
- Beyond the earlier fixed 8-key / 3-song grader it adds: configurable key count and widths, rest notes, a press timeout, wrong-key counting and an explicit done flag.

---
 rtl/learn_mode_grader_if.sv | 35 +++
 rtl/learn_mode_grader.sv | 205 ++++++++++++++++++++
 tb/tb_learn_mode_grader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/learn_mode_grader_if.sv
// Connection bundle between the learn-mode grader and its song ROM, key pad and LED/score display.
// rom_note/rom_dur follow rom_addr by one cycle; music is the key to press while note_valid is high; grade is qualified by a one-cycle grade_valid pulse.
interface learn_mode_grader_if #(
  parameter int NUM_KEYS = 8,
  parameter int NOTE_W   = 5,
  parameter int IDX_W    = 8,
  parameter int DUR_W    = 3,
  parameter int SCORE_W  = 10
);
  logic                start;
  logic [2:0]          song_sel;
  logic [IDX_W-1:0]    song_len;
  logic [IDX_W-1:0]    rom_addr;
  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;
  logic [NUM_KEYS-1:0] touch;
  logic [NOTE_W-1:0]   music;
  logic                note_valid;
  logic [2:0]          grade;
  logic                grade_valid;
  logic [SCORE_W-1:0]  score;
  logic [7:0]          wrong_cnt;
  logic                done;
  logic [3:0]          state_dbg;

  modport master (
    input  start, song_sel, song_len, rom_note, rom_dur, touch,
    output rom_addr, music, note_valid, grade, grade_valid, score, wrong_cnt, done, state_dbg
  );

  modport slave (
    output start, song_sel, song_len, rom_note, rom_dur, touch,
    input  rom_addr, music, note_valid, grade, grade_valid, score, wrong_cnt, done, state_dbg
  );
endinterface

// File: rtl/learn_mode_grader.sv
// Learn-mode note follower: fetches each song note, waits for the matching key,
// times the hold in ticks and grades it against the note duration into a saturating score.
module learn_mode_grader #(
  parameter int NUM_KEYS = 8,
  parameter int NOTE_W   = 5,
  parameter int IDX_W    = 8,
  parameter int DUR_W    = 3,
  parameter int TICK_DIV = 6000,
  parameter int TOL      = 3,
  parameter int TIMEOUT  = 15,
  parameter int SCORE_W  = 10
) (
  input  logic clk,
  input  logic rst,
  learn_mode_grader_if.master bus
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [DUR_W-1:0]   HOLD_MAX  = '1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [NOTE_W-1:0]  NOTE_TOP  = NOTE_W'(21);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    FETCH_A    = 4'd1,
    FETCH_D    = 4'd2,
    REST       = 4'd3,
    WAIT_PRESS = 4'd4,
    HOLD       = 4'd5,
    GRADE      = 4'd6,
    ADVANCE    = 4'd7,
    DONE       = 4'd8
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    rom_addr;
  logic [NOTE_W-1:0]   note;
  logic [DUR_W-1:0]    dur;
  logic [DUR_W-1:0]    hold_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic                timed_out;
  logic [2:0]          last_sel;
  logic [NUM_KEYS-1:0] prev_touch;
  logic [NOTE_W-1:0]   music;
  logic                note_valid;
  logic [2:0]          grade;
  logic                grade_valid;
  logic [SCORE_W-1:0]  score;
  logic [7:0]          wrong_cnt;
  logic                done;

  logic                restart, tick, rom_rest, wrong_hit;
  logic [IDX_W-1:0]    last_idx;
  logic [NOTE_W-1:0]   key_pos;
  logic [NUM_KEYS-1:0] exp_key;
  logic [DUR_W-1:0]    hold_tick, diff;
  logic [31:0]         diff32;
  logic [2:0]          grade_calc;
  logic [SCORE_W:0]    score_sum;
  logic [SCORE_W-1:0]  score_nxt;
  logic [7:0]          wrong_inc;

  assign restart   = bus.start || (bus.song_sel != last_sel);
  assign tick      = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign last_idx  = (bus.song_len == '0) ? '0 : bus.song_len - 1'b1;
  assign rom_rest  = (bus.rom_note == '0) || (bus.rom_note > NOTE_TOP);

  // Seven keys per octave: the note code folds onto one key of the pad.
  assign key_pos   = (note - 1'b1) % NOTE_W'(7);
  assign exp_key   = NUM_KEYS'(1) << key_pos;
  assign wrong_hit = (bus.touch != '0) && (bus.touch != exp_key) && (bus.touch != prev_touch);
  assign wrong_inc = (wrong_cnt == 8'hFF) ? wrong_cnt : wrong_cnt + 8'd1;

  assign hold_tick  = (tick && hold_cnt != HOLD_MAX) ? hold_cnt + 1'b1 : hold_cnt;
  assign diff       = (hold_cnt >= dur) ? hold_cnt - dur : dur - hold_cnt;
  assign diff32     = 32'(diff);
  assign grade_calc = (timed_out || diff32 > TOL) ? 3'd0 : 3'(TOL + 1 - diff32);
  assign score_sum  = {1'b0, score} + (SCORE_W+1)'(grade_calc);
  assign score_nxt  = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      idx         <= '0;
      rom_addr    <= '0;
      note        <= '0;
      dur         <= '0;
      hold_cnt    <= '0;
      to_cnt      <= '0;
      timed_out   <= 1'b0;
      last_sel    <= '0;
      prev_touch  <= '0;
      music       <= '0;
      note_valid  <= 1'b0;
      grade       <= '0;
      grade_valid <= 1'b0;
      score       <= '0;
      wrong_cnt   <= '0;
      done        <= 1'b0;
    end else begin
      grade_valid <= 1'b0;
      prev_touch  <= bus.touch;
      div_cnt     <= tick ? '0 : div_cnt + 1'b1;
      if (restart) begin
        state      <= FETCH_A;
        idx        <= '0;
        rom_addr   <= '0;
        score      <= '0;
        grade      <= '0;
        wrong_cnt  <= '0;
        done       <= 1'b0;
        div_cnt    <= '0;
        last_sel   <= bus.song_sel;
        music      <= '0;
        note_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          FETCH_A: state <= FETCH_D;
          FETCH_D: begin
            // Tick phase restarts with each note so durations are counted from its start.
            note      <= bus.rom_note;
            dur       <= bus.rom_dur;
            div_cnt   <= '0;
            hold_cnt  <= '0;
            to_cnt    <= '0;
            timed_out <= 1'b0;
            if (rom_rest) begin
              state <= REST;
            end else begin
              state      <= WAIT_PRESS;
              music      <= bus.rom_note;
              note_valid <= 1'b1;
            end
          end
          REST: begin
            if (dur == '0) begin
              state <= ADVANCE;
            end else if (tick) begin
              hold_cnt <= hold_cnt + 1'b1;
              if (hold_cnt + 1'b1 == dur) state <= ADVANCE;
            end
          end
          WAIT_PRESS: begin
            if (wrong_hit) wrong_cnt <= wrong_inc;
            if (bus.touch == exp_key) begin
              state    <= HOLD;
              hold_cnt <= '0;
            end else if (tick) begin
              to_cnt <= to_cnt + 1'b1;
              if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                timed_out  <= 1'b1;
                state      <= GRADE;
                music      <= '0;
                note_valid <= 1'b0;
              end
            end
          end
          HOLD: begin
            hold_cnt <= hold_tick;
            if (bus.touch != exp_key) begin
              state      <= GRADE;
              music      <= '0;
              note_valid <= 1'b0;
              if (wrong_hit) wrong_cnt <= wrong_inc;
            end
          end
          GRADE: begin
            grade       <= grade_calc;
            score       <= score_nxt;
            grade_valid <= 1'b1;
            state       <= ADVANCE;
          end
          ADVANCE: begin
            if (idx == last_idx) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              idx      <= idx + 1'b1;
              rom_addr <= idx + 1'b1;
              state    <= FETCH_A;
            end
          end
          DONE: state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rom_addr    = rom_addr;
  assign bus.music       = music;
  assign bus.note_valid  = note_valid;
  assign bus.grade       = grade;
  assign bus.grade_valid = grade_valid;
  assign bus.score       = score;
  assign bus.wrong_cnt   = wrong_cnt;
  assign bus.done        = done;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_learn_mode_grader.sv
// Directed bench for learn_mode_grader: small song ROM model, hand-computed grades and scores.
module tb_learn_mode_grader;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  learn_mode_grader_if #(.NUM_KEYS(8), .NOTE_W(5), .IDX_W(8), .DUR_W(3), .SCORE_W(3)) bus ();

  learn_mode_grader #(
    .NUM_KEYS(8), .NOTE_W(5), .IDX_W(8), .DUR_W(3),
    .TICK_DIV(4), .TOL(3), .TIMEOUT(15), .SCORE_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // song ROM: data follows the address by one clock
  logic [4:0] rom_n [0:255];
  logic [2:0] rom_d [0:255];
  always @(posedge clk) begin
    bus.rom_note <= rom_n[bus.rom_addr];
    bus.rom_dur  <= rom_d[bus.rom_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_note(input int i, input logic [4:0] n, input logic [2:0] d);
    rom_n[i] = n;
    rom_d[i] = d;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic press(input logic [7:0] key, input int cycles);
    bus.touch = key;
    repeat (cycles) @(negedge clk);
    bus.touch = 8'h00;
  endtask

  task automatic wait_nv(input string tag);
    int n = 0;
    while (bus.note_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_note_valid"}, 32'(bus.note_valid), 1);
  endtask

  task automatic wait_gv(input string tag);
    int n = 0;
    while (bus.grade_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_grade_valid"}, 32'(bus.grade_valid), 1);
  endtask

  initial begin
    int  cnt;
    bit  gv_seen, music_seen;

    for (int i = 0; i < 256; i++) begin
      rom_n[i] = '0;
      rom_d[i] = '0;
    end
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.song_sel = 3'd0;
    bus.song_len = 8'd1;
    bus.touch    = 8'h00;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_music", 32'(bus.music), 0);
    chk("rst_note_valid", 32'(bus.note_valid), 0);
    chk("rst_grade", 32'(bus.grade), 0);
    chk("rst_grade_valid", 32'(bus.grade_valid), 0);
    chk("rst_score", 32'(bus.score), 0);
    chk("rst_wrong", 32'(bus.wrong_cnt), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 0);
    chk("rst_state", 32'(bus.state_dbg), 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_state", 32'(bus.state_dbg), 0);

    // exact timing: note 3 dur 2, held 2 ticks
    set_note(0, 5'd3, 3'd2);
    bus.song_len = 8'd1;
    pulse_start();
    wait_nv("exact");
    chk("exact_music", 32'(bus.music), 3);
    press(8'h04, 8);
    wait_gv("exact");
    chk("exact_grade", 32'(bus.grade), 4);
    chk("exact_score", 32'(bus.score), 4);
    @(negedge clk);
    chk("exact_gv_pulse", 32'(bus.grade_valid), 0);
    chk("exact_done", 32'(bus.done), 1);
    chk("exact_done_music", 32'(bus.music), 0);

    // reset mid-song while in HOLD
    pulse_start();
    wait_nv("rstmid");
    press(8'h10, 2);
    bus.touch = 8'h04;
    repeat (3) @(negedge clk);
    chk("rstmid_hold_state", 32'(bus.state_dbg), 5);
    chk("rstmid_wrong", 32'(bus.wrong_cnt), 1);
    rst = 1'b0;
    #1;
    chk("rstmid_music", 32'(bus.music), 0);
    chk("rstmid_note_valid", 32'(bus.note_valid), 0);
    chk("rstmid_wrong0", 32'(bus.wrong_cnt), 0);
    chk("rstmid_state", 32'(bus.state_dbg), 0);
    bus.touch = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("rstmid_idle_state", 32'(bus.state_dbg), 0);
    chk("rstmid_idle_nv", 32'(bus.note_valid), 0);
    chk("rstmid_idle_addr", 32'(bus.rom_addr), 0);

    // off timing: held 5 ticks on dur 2 -> grade 1
    pulse_start();
    wait_nv("off5");
    press(8'h04, 20);
    wait_gv("off5");
    chk("off5_grade", 32'(bus.grade), 1);
    chk("off5_score", 32'(bus.score), 1);

    // two notes: exact then held 7 ticks -> grade 0, score unchanged
    set_note(1, 5'd3, 3'd2);
    bus.song_len = 8'd2;
    pulse_start();
    wait_nv("off7a");
    press(8'h04, 8);
    wait_gv("off7a");
    chk("off7a_score", 32'(bus.score), 4);
    wait_nv("off7b");
    press(8'h04, 28);
    wait_gv("off7b");
    chk("off7_grade", 32'(bus.grade), 0);
    chk("off7_score", 32'(bus.score), 4);
    @(negedge clk);
    chk("off7_done", 32'(bus.done), 1);

    // wrong key twice, then timeout; index advances to note 3
    set_note(0, 5'd1, 3'd1);
    set_note(1, 5'd3, 3'd2);
    pulse_start();
    wait_nv("wrong");
    chk("wrong_music", 32'(bus.music), 1);
    press(8'h10, 2);
    repeat (2) @(negedge clk);
    press(8'h10, 2);
    chk("wrong_cnt2", 32'(bus.wrong_cnt), 2);
    wait_gv("timeout");
    chk("timeout_grade", 32'(bus.grade), 0);
    chk("timeout_score", 32'(bus.score), 0);
    wait_nv("adv");
    chk("adv_music", 32'(bus.music), 3);
    chk("adv_addr", 32'(bus.rom_addr), 1);
    press(8'h04, 8);
    wait_gv("adv");
    chk("adv_grade", 32'(bus.grade), 4);
    chk("adv_wrong", 32'(bus.wrong_cnt), 2);

    // rest of 3 ticks then note 8 (key 0)
    set_note(0, 5'd0, 3'd3);
    set_note(1, 5'd8, 3'd1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    cnt        = 1;
    gv_seen    = 1'b0;
    music_seen = 1'b0;
    while (bus.note_valid !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (bus.grade_valid === 1'b1) gv_seen = 1'b1;
      if (bus.note_valid !== 1'b1 && bus.music !== 5'd0) music_seen = 1'b1;
    end
    chk("rest_latency", cnt, 18);
    chk("rest_no_grade", 32'(gv_seen), 0);
    chk("rest_music0", 32'(music_seen), 0);
    chk("rest_next_music", 32'(bus.music), 8);
    press(8'h01, 4);
    wait_gv("rest");
    chk("rest_grade", 32'(bus.grade), 4);
    @(negedge clk);
    chk("rest_done", 32'(bus.done), 1);
    chk("rest_done_music", 32'(bus.music), 0);
    chk("rest_done_nv", 32'(bus.note_valid), 0);

    // restart by song_sel change mid-HOLD
    set_note(0, 5'd3, 3'd2);
    set_note(1, 5'd3, 3'd4);
    set_note(2, 5'd3, 3'd2);
    bus.song_len = 8'd3;
    pulse_start();
    wait_nv("sel1");
    press(8'h10, 2);
    press(8'h04, 8);
    wait_gv("sel1");
    chk("sel_pre_score", 32'(bus.score), 4);
    chk("sel_pre_wrong", 32'(bus.wrong_cnt), 1);
    wait_nv("sel2");
    bus.touch = 8'h04;
    repeat (3) @(negedge clk);
    chk("sel_hold_state", 32'(bus.state_dbg), 5);
    bus.song_sel = 3'd1;
    @(negedge clk);
    chk("sel_score0", 32'(bus.score), 0);
    chk("sel_wrong0", 32'(bus.wrong_cnt), 0);
    chk("sel_addr0", 32'(bus.rom_addr), 0);
    chk("sel_fetch_a", 32'(bus.state_dbg), 1);
    bus.touch = 8'h00;
    @(negedge clk);
    chk("sel_fetch_d", 32'(bus.state_dbg), 2);

    // saturation: 4 + 2 = 6, then +4 saturates at 7
    wait_nv("sat1");
    press(8'h04, 8);
    wait_gv("sat1");
    chk("sat1_score", 32'(bus.score), 4);
    wait_nv("sat2");
    press(8'h04, 8);
    wait_gv("sat2");
    chk("sat2_grade", 32'(bus.grade), 2);
    chk("sat2_score", 32'(bus.score), 6);
    wait_nv("sat3");
    press(8'h04, 8);
    wait_gv("sat3");
    chk("sat3_grade", 32'(bus.grade), 4);
    chk("sat3_score", 32'(bus.score), 7);
    @(negedge clk);
    chk("sat_done", 32'(bus.done), 1);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
